spdp7_mem_responder: RTL and testbench

Memory-side responder for the serial PDP-8 memory bus driven by pdp8_cpu. It holds a 128 x 12-bit core image. Each cycle it answers the CPU's bit-serial read or write (ma, ba, mb, write) by driving membus. A host-side serial loader/dumper initializes or extracts the image while the CPU is halted, then issues the contin pulse that restarts the CPU.

---
 rtl/spdp7_pkg.sv | 22 ++
 rtl/spdp7_core_ram.sv | 47 ++++
 rtl/spdp7_mem_responder.sv | 148 ++++++++++++++
 tb/tb_spdp7_mem_responder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/spdp7_pkg.sv
// Shared constants and encodings for the serial PDP-8 memory responder.
// Address/word/bit-index widths, the responder FSM states, and the host command encoding.
package spdp7_pkg;

  localparam int AW    = 7;
  localparam int WW    = 12;
  localparam int BW    = 4;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DUMP = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef enum logic {
    CMD_LOAD = 1'b0,
    CMD_DUMP = 1'b1
  } cmd_e;

endpackage

// File: rtl/spdp7_core_ram.sv
// 128 x 12 core image: loader word-write port, CPU bit-write port, registered bit read.
// The word write wins if both write ports are ever enabled together.
module spdp7_core_ram
  import spdp7_pkg::*;
(
  input  logic          sysclk_i,
  input  logic          reset_i,
  input  logic          word_we_i,
  input  logic [AW-1:0] word_addr_i,
  input  logic [WW-1:0] word_data_i,
  input  logic          bit_we_i,
  input  logic [AW-1:0] bit_addr_i,
  input  logic [BW-1:0] bit_idx_i,
  input  logic          bit_data_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  input  logic [BW-1:0] rd_idx_i,
  output logic          rd_bit_o
);

  logic [WW-1:0] mem [DEPTH];
  logic          rd_bit_q;

  // NOTE: the array has no reset; the image must survive a reset, and leaving
  // it out also lets the array map onto RAM.
  always_ff @(posedge sysclk_i) begin
    if (word_we_i) begin
      mem[word_addr_i] <= word_data_i;
    end else if (bit_we_i) begin
      mem[bit_addr_i][bit_idx_i] <= bit_data_i;
    end
  end

  // Reads before the write of the same edge, so a same-cycle read sees the old bit.
  always_ff @(posedge sysclk_i) begin
    if (reset_i) begin
      rd_bit_q <= 1'b0;
    end else if (rd_en_i) begin
      rd_bit_q <= mem[rd_addr_i][rd_idx_i];
    end else begin
      rd_bit_q <= 1'b0;
    end
  end

  assign rd_bit_o = rd_bit_q;

endmodule

// File: rtl/spdp7_mem_responder.sv
// Memory-side responder for the bit-serial PDP-8 bus, with a host serial loader/dumper
// that fills or extracts the core image while the CPU is halted.
module spdp7_mem_responder
  import spdp7_pkg::*;
(
  input  logic          sysclk,
  input  logic          reset,
  input  logic [AW-1:0] ma,
  input  logic [BW-1:0] ba,
  input  logic          mb,
  input  logic          write,
  input  logic          halt,
  output logic          membus,
  output logic          contin,
  input  logic          host_start,
  input  logic          host_dump,
  input  logic [AW-1:0] host_addr,
  input  logic [AW:0]   host_count,
  input  logic          host_run,
  input  logic          host_bit,
  input  logic          host_valid,
  output logic          dump_bit,
  output logic          dump_valid,
  output logic          busy
);

  localparam logic [AW:0]   COUNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   COUNT_ONE  = (AW+1)'(1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(WW-1);
  localparam logic [BW-1:0] BA_LIMIT   = BW'(WW);

  state_e        state_q;
  logic [AW-1:0] addr_q;
  logic [AW:0]   count_q;
  logic [BW-1:0] bitcnt_q;
  logic [WW-2:0] shift_q;
  logic          run_q;
  logic          busy_q;
  logic          contin_q;
  logic          dump_valid_q;

  logic          ba_ok_d;
  logic          last_bit_d;
  logic          cpu_we_d;
  logic          word_we_d;
  logic          rd_en_d;
  logic [AW-1:0] rd_addr_d;
  logic [BW-1:0] rd_idx_d;
  logic          rd_bit;

  assign ba_ok_d    = (ba < BA_LIMIT);
  assign last_bit_d = (bitcnt_q == BIT_LAST);
  assign cpu_we_d   = (state_q == ST_IDLE) && write && ba_ok_d;
  assign word_we_d  = (state_q == ST_LOAD) && host_valid && last_bit_d;

  // The dumper borrows the CPU's bit-read port; only one of them is ever active.
  assign rd_en_d   = ((state_q == ST_IDLE) && ba_ok_d) || (state_q == ST_DUMP);
  assign rd_addr_d = (state_q == ST_DUMP) ? addr_q   : ma;
  assign rd_idx_d  = (state_q == ST_DUMP) ? bitcnt_q : ba;

  spdp7_core_ram u_ram (
    .sysclk_i    (sysclk),
    .reset_i     (reset),
    .word_we_i   (word_we_d),
    .word_addr_i (addr_q),
    .word_data_i ({host_bit, shift_q}),
    .bit_we_i    (cpu_we_d),
    .bit_addr_i  (ma),
    .bit_idx_i   (ba),
    .bit_data_i  (mb),
    .rd_en_i     (rd_en_d),
    .rd_addr_i   (rd_addr_d),
    .rd_idx_i    (rd_idx_d),
    .rd_bit_o    (rd_bit)
  );

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      count_q      <= '0;
      bitcnt_q     <= '0;
      shift_q      <= '0;
      run_q        <= 1'b0;
      busy_q       <= 1'b0;
      contin_q     <= 1'b0;
      dump_valid_q <= 1'b0;
    end else begin
      contin_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (host_start && halt) begin
            state_q  <= (cmd_e'(host_dump) == CMD_DUMP) ? ST_DUMP : ST_LOAD;
            addr_q   <= host_addr;
            count_q  <= (host_count == '0) ? COUNT_FULL : host_count;
            bitcnt_q <= '0;
            run_q    <= host_run && (cmd_e'(host_dump) == CMD_LOAD);
            busy_q   <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (host_valid) begin
            if (last_bit_d) begin
              bitcnt_q <= '0;
              addr_q   <= addr_q + 1'b1;
              count_q  <= count_q - 1'b1;
              if (count_q == COUNT_ONE) begin
                state_q  <= ST_DONE;
                busy_q   <= 1'b0;
                contin_q <= run_q;
              end
            end else begin
              shift_q[bitcnt_q] <= host_bit;
              bitcnt_q          <= bitcnt_q + 1'b1;
            end
          end
        end
        ST_DUMP: begin
          dump_valid_q <= 1'b1;
          if (last_bit_d) begin
            bitcnt_q <= '0;
            addr_q   <= addr_q + 1'b1;
            count_q  <= count_q - 1'b1;
            if (count_q == COUNT_ONE) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
            end
          end else begin
            bitcnt_q <= bitcnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          dump_valid_q <= 1'b0;
          state_q      <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // The shared read register carries dump data while dumping, so membus is masked then.
  assign membus     = rd_bit & ~busy_q & ~dump_valid_q;
  assign dump_bit   = rd_bit & dump_valid_q;
  assign dump_valid = dump_valid_q;
  assign contin     = contin_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_spdp7_mem_responder.sv
// Directed bench for spdp7_mem_responder: CPU bit access, host load/dump, contin, reset mid-load.
module tb_spdp7_mem_responder;
  import spdp7_pkg::*;

  logic          sysclk = 1'b0;
  logic          reset, mb, write, halt;
  logic [AW-1:0] ma, host_addr;
  logic [BW-1:0] ba;
  logic          membus, contin;
  logic          host_start, host_dump, host_run, host_bit, host_valid;
  logic [AW:0]   host_count;
  logic          dump_bit, dump_valid, busy;

  int checks      = 0;
  int failures    = 0;
  int contin_cnt  = 0;

  always #5 sysclk = ~sysclk;

  spdp7_mem_responder dut (
    .sysclk     (sysclk),
    .reset      (reset),
    .ma         (ma),
    .ba         (ba),
    .mb         (mb),
    .write      (write),
    .halt       (halt),
    .membus     (membus),
    .contin     (contin),
    .host_start (host_start),
    .host_dump  (host_dump),
    .host_addr  (host_addr),
    .host_count (host_count),
    .host_run   (host_run),
    .host_bit   (host_bit),
    .host_valid (host_valid),
    .dump_bit   (dump_bit),
    .dump_valid (dump_valid),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge sysclk);
    #1;
    if (contin === 1'b1) contin_cnt++;
  endtask

  task automatic cpu_write(input logic [AW-1:0] a, input logic [BW-1:0] b, input logic d);
    ma = a; ba = b; mb = d; write = 1'b1;
    tick();
    write = 1'b0; mb = 1'b0;
  endtask

  task automatic read_word(input logic [AW-1:0] a, output logic [WW-1:0] w);
    for (int b = 0; b < WW; b++) begin
      ma = a; ba = BW'(b);
      tick();
      w[b] = membus;
    end
  endtask

  task automatic host_cmd(input logic d, input logic [AW-1:0] a, input logic [AW:0] c,
                          input logic r);
    host_start = 1'b1; host_dump = d; host_addr = a; host_count = c; host_run = r;
    tick();
    host_start = 1'b0;
  endtask

  task automatic load_words(input logic [WW-1:0] w0, input logic [WW-1:0] w1,
                            input logic [WW-1:0] w2, input int nbits,
                            output logic all_busy, output logic any_busy);
    logic [WW-1:0] w [3];
    w[0] = w0; w[1] = w1; w[2] = w2;
    all_busy = 1'b1; any_busy = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      repeat ($urandom_range(0, 2)) begin
        host_valid = 1'b0;
        all_busy &= busy; any_busy |= busy;
        tick();
      end
      host_valid = 1'b1;
      host_bit   = w[i / WW][i % WW];
      all_busy &= busy; any_busy |= busy;
      tick();
    end
    host_valid = 1'b0;
  endtask

  initial begin
    logic [WW-1:0] w;
    logic [WW-1:0] got [3];
    logic          all_b, any_b, all_v, mb_zero;

    reset = 1'b1; ma = '0; ba = '0; mb = 1'b0; write = 1'b0; halt = 1'b0;
    host_start = 1'b0; host_dump = 1'b0; host_addr = '0; host_count = '0;
    host_run = 1'b0; host_bit = 1'b0; host_valid = 1'b0;
    repeat (2) tick();
    check("rst_membus", membus, 0);
    check("rst_contin", contin, 0);
    check("rst_dump_bit", dump_bit, 0);
    check("rst_dump_valid", dump_valid, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;

    // CPU bit access on word 5
    for (int b = 0; b < WW; b++) cpu_write(7'd5, BW'(b), 1'b0);
    cpu_write(7'd5, 4'd3, 1'b1);
    check("same_cycle_old", membus, 0);
    ma = 7'd5; ba = 4'd3; tick();
    check("read_new_b3", membus, 1);
    ba = 4'd2; tick();
    check("read_b2", membus, 0);

    // ba out of range
    cpu_write(7'd5, 4'd13, 1'b1);
    check("read_ba13_w", membus, 0);
    ba = 4'd13; tick();
    check("read_ba13", membus, 0);
    read_word(7'd5, w);
    check("word5_unchanged", w, 12'o0010);

    // LOAD across the address wrap, no run
    halt = 1'b1; contin_cnt = 0;
    host_cmd(1'b0, 7'd126, 8'd3, 1'b0);
    load_words(12'o7777, 12'o1234, 12'o0001, 36, all_b, any_b);
    check("load_busy_all", all_b, 1);
    check("load_done_contin", contin, 0);
    check("load_done_busy", busy, 0);
    tick(); tick();
    check("load_contin_cnt", contin_cnt, 0);
    read_word(7'd126, w); check("mem126", w, 12'o7777);
    read_word(7'd127, w); check("mem127", w, 12'o1234);
    read_word(7'd0,   w); check("mem0",   w, 12'o0001);

    // LOAD with run: one contin pulse in the DONE cycle
    contin_cnt = 0;
    host_cmd(1'b0, 7'd126, 8'd3, 1'b1);
    load_words(12'o7777, 12'o1234, 12'o0001, 36, all_b, any_b);
    check("run_busy_all", all_b, 1);
    check("run_contin_done", contin, 1);
    tick(); tick(); tick();
    check("run_contin_cnt", contin_cnt, 1);

    // LOAD while running (halt=0) is ignored
    halt = 1'b0; contin_cnt = 0;
    host_cmd(1'b0, 7'd126, 8'd3, 1'b1);
    load_words(12'o5555, 12'o5555, 12'o5555, 36, all_b, any_b);
    tick();
    check("nohalt_busy", any_b, 0);
    check("nohalt_contin_cnt", contin_cnt, 0);
    read_word(7'd126, w); check("nohalt_mem126", w, 12'o7777);
    read_word(7'd127, w); check("nohalt_mem127", w, 12'o1234);
    read_word(7'd0,   w); check("nohalt_mem0",   w, 12'o0001);
    halt = 1'b1;

    // DUMP across the wrap with a CPU write attempt throughout
    host_cmd(1'b1, 7'd126, 8'd3, 1'b0);
    check("dump_latency", dump_valid, 0);
    check("dump_busy", busy, 1);
    ma = 7'd126; ba = 4'd0; mb = 1'b0; write = 1'b1;
    all_v = 1'b1; mb_zero = 1'b1;
    for (int i = 0; i < 3 * WW; i++) begin
      tick();
      all_v &= dump_valid;
      mb_zero &= ~membus;
      got[i / WW][i % WW] = dump_bit;
    end
    write = 1'b0;
    check("dump_done_busy", busy, 0);
    tick();
    check("dump_valid_all", all_v, 1);
    check("dump_valid_end", dump_valid, 0);
    check("dump_membus_zero", mb_zero, 1);
    check("dump_w0", got[0], 12'o7777);
    check("dump_w1", got[1], 12'o1234);
    check("dump_w2", got[2], 12'o0001);
    read_word(7'd126, w); check("dump_mem126", w, 12'o7777);

    // Reset after 20 bits: first word lands, second is discarded
    host_cmd(1'b0, 7'd126, 8'd3, 1'b0);
    load_words(12'o0505, 12'o0660, 12'o0777, 20, all_b, any_b);
    check("rstmid_busy_before", busy, 1);
    reset = 1'b1; tick(); reset = 1'b0;
    check("rstmid_busy", busy, 0);
    check("rstmid_dump_valid", dump_valid, 0);
    read_word(7'd126, w); check("rstmid_mem126", w, 12'o0505);
    read_word(7'd127, w); check("rstmid_mem127", w, 12'o1234);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
